// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: pipelined MIPS branch comparator.
// Evaluates one of six branch conditions on two operands and carries the result
// through STAGES (1 or 2) registered stages under a valid/ready handshake with flush.
// Optional build macro CMP_STATS_EN enables the saturating taken-branch counter;
// without it taken_cnt is tied to zero.
module branch_cmp_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             eq,
    output logic             gez,
    output logic             gtz,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt
);

    // Result word layout: {taken, eq, gez, gtz, illegal}
    localparam int PW = 5;

    generate
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("branch_cmp_pipe: STAGES must be 1 or 2");
        end
    endgenerate

    logic          eq_c;
    logic          gez_c;
    logic          gtz_c;
    logic          taken_c;
    logic          illegal_c;
    logic [PW-1:0] in_word;
    logic          adv;
    logic          accept;

    logic          valid_q [STAGES];
    logic [PW-1:0] word_q  [STAGES];
    logic          valid_d [STAGES];
    logic [PW-1:0] word_d  [STAGES];

    // Raw flags and resolved decision for the request at the input
    always_comb begin
        eq_c      = (a == b);
        gez_c     = !a[WIDTH-1];
        gtz_c     = !a[WIDTH-1] && (a != '0);
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (op)
            3'd0:    taken_c = eq_c;
            3'd1:    taken_c = !eq_c;
            3'd2:    taken_c = gez_c;
            3'd3:    taken_c = gtz_c;
            3'd4:    taken_c = !gtz_c;
            3'd5:    taken_c = !gez_c;
            default: illegal_c = 1'b1;
        endcase
    end

    assign in_word   = {taken_c, eq_c, gez_c, gtz_c, illegal_c};
    assign out_valid = valid_q[STAGES-1];
    // Whole pipe moves together: any stall freezes every stage, so bubbles never collapse
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv && !flush;

    // Shift source for each stage: stage 0 takes the new request, later stages their predecessor
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_d[gi] = accept;
                assign word_d[gi]  = accept ? in_word : word_q[gi];
            end else begin : g_tail
                assign valid_d[gi] = valid_q[gi-1];
                assign word_d[gi]  = word_q[gi-1];
            end
        end
    endgenerate

    // Stage registers: reset beats flush, flush clears valids, otherwise shift on advance
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (reset) begin
                valid_q[i] <= 1'b0;
                word_q[i]  <= '0;
            end else begin
                if (flush) begin
                    valid_q[i] <= 1'b0;
                end else if (adv) begin
                    valid_q[i] <= valid_d[i];
                end
                if (adv) begin
                    word_q[i] <= word_d[i];
                end
            end
        end
    end

    assign {taken, eq, gez, gtz, illegal} = word_q[STAGES-1];

`ifdef CMP_STATS_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consumed taken results, sticking at all-ones; flush does not affect it
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && taken && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign taken_cnt = cnt_q;
`else
    assign taken_cnt = '0;
`endif

endmodule

// File: doc/branch_cmp_pipe.md
Name: branch_cmp_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator in the MIPS datapath.
- Evaluates one of six branch conditions on two GPR-width operands.
- Carries each result through STAGES registered stages with a valid/ready handshake and a flush input, so the decode/execute boundary can stall or squash it.
- Exposes raw flags (eq, gez, gtz) plus a resolved taken bit.

Parameters:
- WIDTH, 32, operand width in bits (>= 2).
- STAGES, 1, pipeline depth; legal values 1 or 2; any other value is an elaboration error.
- CNT_W, 16, width of the taken-branch statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present this cycle.
- in_ready  output  1  unit can accept a request this cycle.
- op  input  3  condition: 0 BEQ, 1 BNE, 2 BGEZ, 3 BGTZ, 4 BLEZ, 5 BLTZ, 6-7 illegal.
- a  input  WIDTH  operand rs (two's complement).
- b  input  WIDTH  operand rt (used only by BEQ/BNE).
- flush  input  1  squash all in-flight and incoming requests.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- taken  output  1  resolved branch decision.
- eq  output  1  a == b.
- gez  output  1  signed a >= 0.
- gtz  output  1  signed a > 0.
- illegal  output  1  op was 6 or 7.
- taken_cnt  output  CNT_W  count of consumed taken results.

Behaviour:
- Reset (synchronous, sampled on clk rising edge): all stage valid bits = 0; out_valid = 0; taken, eq, gez and gtz = 0; illegal = 0; taken_cnt = 0. Reset wins over flush and over any handshake in the same cycle.
- Flags are computed combinationally at input:
  - eq = (a == b).
  - gez = !a[WIDTH-1].
  - gtz = !a[WIDTH-1] && (a != 0).
- taken by op:
  - BEQ: eq.
  - BNE: !eq.
  - BGEZ: gez.
  - BGTZ: gtz.
  - BLEZ: !gtz.
  - BLTZ: !gez.
  - 6/7: taken = 0, illegal = 1.
- Flags, taken and illegal travel with the request, registered as one word per stage with one valid bit.
- Global advance: adv = !out_valid || out_ready. When adv = 1, every stage shifts one place; when adv = 0, all stages hold.
- in_ready = adv. A request is accepted when in_valid && in_ready && !flush.
- Latency: a request accepted on edge N presents out_valid = 1 with its result after edge N+STAGES-1, i.e. it is visible in cycle N+STAGES. Each stall cycle adds exactly one cycle.
- Bubbles do not collapse: an empty stage ahead of a stalled full stage stays empty.
- Throughput: one result per cycle while out_ready = 1.
- Result fields hold stable while out_valid && !out_ready. Fields are don't-care when out_valid = 0 but must not be X after reset.
- flush = 1: on that edge all valid bits clear, the input is dropped, and out_valid = 0 next cycle. A result handshaken (out_valid && out_ready) in the flush cycle counts as consumed.
- Counter: taken_cnt += 1 on edge when out_valid && out_ready && taken. Saturates at 2^CNT_W-1 with no wrap. Unaffected by flush.
- Reset mid-operation discards all in-flight requests with no residual outputs.

Optional Feature:
- Macro: CMP_STATS_EN.
- Defined: taken_cnt is implemented as above.
- Undefined: no counter register; taken_cnt is tied to 0; all other behaviour is identical.

Test Plan:
- Reset with in-flight data (STAGES=2, two requests queued, reset high 1 cycle) -> next cycle out_valid=0, taken_cnt=0, in_ready=1.
- STAGES=1, out_ready=1, stream of six ops:
  - BEQ a=5,b=5
  - BNE a=5,b=5
  - BGEZ a=0
  - BGTZ a=0
  - BLEZ a=0x80000000
  - BLTZ a=1
  -> results one cycle after each acceptance: taken=1,0,1,0,1,0; eq/gez/gtz match the definitions.
- Signed boundaries (WIDTH=32): a=0x7FFFFFFF -> gez=1,gtz=1; a=0xFFFFFFFF -> gez=0,gtz=0; op=6 -> taken=0, illegal=1.
- Backpressure (STAGES=2): hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 after the pipe fills, output fields stable; release -> results emerge in order with none lost or duplicated.
- Flush (STAGES=2): two requests in flight plus one at input, flush=1 -> out_valid=0 next cycle, and none of those three ever appear.
- Counter (CMP_STATS_EN defined, CNT_W=2): five consumed taken results -> taken_cnt sequence 1,2,3,3,3. A not-taken result or a stalled taken result does not increment. With the macro undefined, taken_cnt stays 0.
